object_motion_pool: RTL and testbench

- Parametrised successor to the single-object position controller: a pool of NUM_SLOTS independent moving objects.
- Each slot has:
  - a signed fixed-point position, direction, speed and size;
  - a lifetime in seconds;
  - a destroy/bounce mode.
- New objects arrive through a valid/ready spawn port and go to the lowest free slot.
- Sits between the pattern/attack sequencer (spawn source) and the renderer/collision logic (position consumers).

---
 rtl/object_pool_pkg.sv | 64 ++++++
 rtl/object_slot_motion.sv | 139 +++++++++++++
 rtl/object_motion_pool.sv | 125 ++++++++++++
 tb/tb_object_motion_pool.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/object_pool_pkg.sv
// Shared constants and direction helpers for the moving-object pool.
// Directions run clockwise from up; modes select what happens at an edge.
package object_pool_pkg;

    localparam logic [2:0] DIR_U  = 3'd0;
    localparam logic [2:0] DIR_UR = 3'd1;
    localparam logic [2:0] DIR_R  = 3'd2;
    localparam logic [2:0] DIR_DR = 3'd3;
    localparam logic [2:0] DIR_D  = 3'd4;
    localparam logic [2:0] DIR_DL = 3'd5;
    localparam logic [2:0] DIR_L  = 3'd6;
    localparam logic [2:0] DIR_UL = 3'd7;

    localparam logic [1:0] MODE_NONE   = 2'd0;
    localparam logic [1:0] MODE_SCREEN = 2'd1;
    localparam logic [1:0] MODE_WINDOW = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    function automatic logic [2:0] mirror_h(input logic [2:0] d);
        case (d)
            DIR_UR:  mirror_h = DIR_UL;
            DIR_R:   mirror_h = DIR_L;
            DIR_DR:  mirror_h = DIR_DL;
            DIR_DL:  mirror_h = DIR_DR;
            DIR_L:   mirror_h = DIR_R;
            DIR_UL:  mirror_h = DIR_UR;
            default: mirror_h = d;
        endcase
    endfunction

    function automatic logic [2:0] mirror_v(input logic [2:0] d);
        case (d)
            DIR_U:   mirror_v = DIR_D;
            DIR_D:   mirror_v = DIR_U;
            DIR_UR:  mirror_v = DIR_DR;
            DIR_DR:  mirror_v = DIR_UR;
            DIR_UL:  mirror_v = DIR_DL;
            DIR_DL:  mirror_v = DIR_UL;
            default: mirror_v = d;
        endcase
    endfunction

    // +1 / -1 / 0 step sign along x; right is positive
    function automatic logic signed [1:0] dir_dx(input logic [2:0] d);
        case (d)
            DIR_UR, DIR_R, DIR_DR: dir_dx = 2'sb01;
            DIR_DL, DIR_L, DIR_UL: dir_dx = 2'sb11;
            default:               dir_dx = 2'sb00;
        endcase
    endfunction

    // +1 / -1 / 0 step sign along y; up is negative
    function automatic logic signed [1:0] dir_dy(input logic [2:0] d);
        case (d)
            DIR_UL, DIR_U, DIR_UR: dir_dy = 2'sb11;
            DIR_DR, DIR_D, DIR_DL: dir_dy = 2'sb01;
            default:               dir_dy = 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/object_slot_motion.sv
// One object slot: fixed-point position, heading, lifetime and exit/bounce handling.
// Only the active flag is reset; the data registers are always rewritten by load.
module object_slot_motion
    import object_pool_pkg::*;
#(
    parameter int FRAC_BITS = 3,
    parameter int SPEED_W   = 5,
    parameter int LIFE_W    = 8,
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H
) (
    input  logic               clk_centi_second,
    input  logic               reset,
    input  logic               load,
    input  logic               kill,
    input  logic               sec_tick,
    input  logic [9:0]         load_x,
    input  logic [9:0]         load_y,
    input  logic [9:0]         load_w,
    input  logic [9:0]         load_h,
    input  logic [2:0]         load_dir,
    input  logic [SPEED_W-1:0] load_speed,
    input  logic [LIFE_W-1:0]  load_life,
    input  logic [1:0]         load_mode,
    input  logic [9:0]         win_x1,
    input  logic [9:0]         win_y1,
    input  logic [9:0]         win_x2,
    input  logic [9:0]         win_y2,
    output logic               active,
    output logic               active_nxt,
    output logic               free_evt,
    output logic [10:0]        obj_x,
    output logic [10:0]        obj_y,
    output logic [9:0]         obj_w,
    output logic [9:0]         obj_h
);
    localparam int POS_W = 11 + FRAC_BITS;
    localparam int CMP_W = 13;

    logic signed [POS_W-1:0] pos_x, pos_y;
    logic [9:0]              size_w, size_h;
    logic [2:0]              dir;
    logic [SPEED_W-1:0]      speed;
    logic [LIFE_W-1:0]       life;
    logic [1:0]              mode;

    logic signed [POS_W-1:0] step, nx, ny, bx, by;
    logic signed [CMP_W-1:0] nx_i, ny_i, w_s, h_s, lo_x, hi_x, lo_y, hi_y;
    logic [10:0]             clamp_x, clamp_y;
    logic                    hit_xl, hit_xh, hit_yl, hit_yh, bounce;
    logic                    exit_hit, life_expire;
    logic [2:0]              ndir;

    assign step = $signed({{(POS_W-SPEED_W){1'b0}}, speed});

    always_comb begin
        nx = pos_x;
        ny = pos_y;
        if (dir_dx(dir) == 2'sb01)      nx = pos_x + step;
        else if (dir_dx(dir) == 2'sb11) nx = pos_x - step;
        if (dir_dy(dir) == 2'sb01)      ny = pos_y + step;
        else if (dir_dy(dir) == 2'sb11) ny = pos_y - step;

        // integer pixel part of the moved position, widened for overflow-free compares
        nx_i = {{(CMP_W-11){nx[POS_W-1]}}, nx[POS_W-1:FRAC_BITS]};
        ny_i = {{(CMP_W-11){ny[POS_W-1]}}, ny[POS_W-1:FRAC_BITS]};
        w_s  = {3'b000, size_w};
        h_s  = {3'b000, size_h};

        if (mode == MODE_SCREEN) begin
            lo_x = '0;
            hi_x = CMP_W'(SCREEN_W);
            lo_y = '0;
            hi_y = CMP_W'(SCREEN_H);
        end else begin
            lo_x = {3'b000, win_x1};
            hi_x = {3'b000, win_x2};
            lo_y = {3'b000, win_y1};
            hi_y = {3'b000, win_y2};
        end

        exit_hit = ((mode == MODE_SCREEN) || (mode == MODE_WINDOW)) &&
                   ((nx_i >= hi_x) || (nx_i + w_s <= lo_x) ||
                    (ny_i >= hi_y) || (ny_i + h_s <= lo_y));

        bounce  = (mode == MODE_BOUNCE);
        hit_xl  = bounce && (nx_i < lo_x);
        hit_xh  = bounce && (nx_i + w_s > hi_x);
        hit_yl  = bounce && (ny_i < lo_y);
        hit_yh  = bounce && (ny_i + h_s > hi_y);
        clamp_x = hit_xl ? {1'b0, win_x1} : ({1'b0, win_x2} - {1'b0, size_w});
        clamp_y = hit_yl ? {1'b0, win_y1} : ({1'b0, win_y2} - {1'b0, size_h});

        bx   = nx;
        by   = ny;
        ndir = dir;
        if (hit_xl || hit_xh) begin
            bx   = {clamp_x, {FRAC_BITS{1'b0}}};
            ndir = mirror_h(ndir);
        end
        if (hit_yl || hit_yh) begin
            by   = {clamp_y, {FRAC_BITS{1'b0}}};
            ndir = mirror_v(ndir);
        end

        life_expire = sec_tick && (life == LIFE_W'(1));
        free_evt    = active && (kill || life_expire || exit_hit);
        active_nxt  = load || (active && !free_evt);
    end

    always_ff @(posedge clk_centi_second) begin
        if (reset) active <= 1'b0;
        else       active <= active_nxt;
    end

    always_ff @(posedge clk_centi_second) begin
        if (load) begin
            pos_x  <= $signed({1'b0, load_x, {FRAC_BITS{1'b0}}});
            pos_y  <= $signed({1'b0, load_y, {FRAC_BITS{1'b0}}});
            size_w <= load_w;
            size_h <= load_h;
            dir    <= load_dir;
            speed  <= load_speed;
            life   <= load_life;
            mode   <= load_mode;
        end else if (active) begin
            pos_x <= bx;
            pos_y <= by;
            dir   <= ndir;
            if (sec_tick && (life != '0)) life <= life - LIFE_W'(1);
        end
    end

    assign obj_x = active ? pos_x[POS_W-1:FRAC_BITS] : 11'd0;
    assign obj_y = active ? pos_y[POS_W-1:FRAC_BITS] : 11'd0;
    assign obj_w = active ? size_w : 10'd0;
    assign obj_h = active ? size_h : 10'd0;

endmodule

// File: rtl/object_motion_pool.sv
// Pool of independently moving objects: second prescaler, lowest-free-slot
// allocator for the spawn port, per-slot motion units and flattened outputs.
module object_motion_pool
    import object_pool_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int FRAC_BITS     = 3,
    parameter int SPEED_W       = 5,
    parameter int LIFE_W        = 8,
    parameter int TICKS_PER_SEC = 100,
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int SCREEN_H      = DEF_SCREEN_H
) (
    input  logic                    clk_centi_second,
    input  logic                    reset,
    input  logic                    spawn_valid,
    output logic                    spawn_ready,
    input  logic [9:0]              spawn_pos_x,
    input  logic [9:0]              spawn_pos_y,
    input  logic [9:0]              spawn_w,
    input  logic [9:0]              spawn_h,
    input  logic [2:0]              spawn_dir,
    input  logic [SPEED_W-1:0]      spawn_speed,
    input  logic [LIFE_W-1:0]       spawn_life,
    input  logic [1:0]              spawn_mode,
    output logic [3:0]              spawn_slot_id,
    input  logic [9:0]              win_x1,
    input  logic [9:0]              win_y1,
    input  logic [9:0]              win_x2,
    input  logic [9:0]              win_y2,
    input  logic [NUM_SLOTS-1:0]    kill_mask,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [11*NUM_SLOTS-1:0] obj_x_flat,
    output logic [11*NUM_SLOTS-1:0] obj_y_flat,
    output logic [10*NUM_SLOTS-1:0] obj_w_flat,
    output logic [10*NUM_SLOTS-1:0] obj_h_flat,
    output logic [NUM_SLOTS-1:0]    destroy_pulse,
    output logic [4:0]              active_count
);
    localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [PS_W-1:0]      ps_cnt;
    logic                 sec_tick;
    logic [NUM_SLOTS-1:0] active_nxt, free_evt, load;
    logic [3:0]           grant_id;
    logic                 grant_ok;

    function automatic logic [4:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) n = n + {4'b0000, v[i]};
        return n;
    endfunction

    assign sec_tick = (ps_cnt == PS_W'(TICKS_PER_SEC - 1));

    always_ff @(posedge clk_centi_second) begin
        if (reset || sec_tick) ps_cnt <= '0;
        else                   ps_cnt <= ps_cnt + PS_W'(1);
    end

    // grant from the registered active flags, so a slot freed this edge waits one tick
    always_comb begin
        grant_id = '0;
        grant_ok = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_active[i] && !grant_ok) begin
                grant_id = 4'(i);
                grant_ok = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            load[i] = spawn_valid && grant_ok && (grant_id == 4'(i));
        end
    end

    assign spawn_ready   = grant_ok;
    assign spawn_slot_id = grant_id;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        object_slot_motion #(
            .FRAC_BITS (FRAC_BITS),
            .SPEED_W   (SPEED_W),
            .LIFE_W    (LIFE_W),
            .SCREEN_W  (SCREEN_W),
            .SCREEN_H  (SCREEN_H)
        ) u_slot (
            .clk_centi_second (clk_centi_second),
            .reset            (reset),
            .load             (load[g]),
            .kill             (kill_mask[g]),
            .sec_tick         (sec_tick),
            .load_x           (spawn_pos_x),
            .load_y           (spawn_pos_y),
            .load_w           (spawn_w),
            .load_h           (spawn_h),
            .load_dir         (spawn_dir),
            .load_speed       (spawn_speed),
            .load_life        (spawn_life),
            .load_mode        (spawn_mode),
            .win_x1           (win_x1),
            .win_y1           (win_y1),
            .win_x2           (win_x2),
            .win_y2           (win_y2),
            .active           (slot_active[g]),
            .active_nxt       (active_nxt[g]),
            .free_evt         (free_evt[g]),
            .obj_x            (obj_x_flat[g*11 +: 11]),
            .obj_y            (obj_y_flat[g*11 +: 11]),
            .obj_w            (obj_w_flat[g*10 +: 10]),
            .obj_h            (obj_h_flat[g*10 +: 10])
        );
    end

    always_ff @(posedge clk_centi_second) begin
        if (reset) begin
            destroy_pulse <= '0;
            active_count  <= '0;
        end else begin
            destroy_pulse <= free_evt;
            active_count  <= popcount(active_nxt);
        end
    end

endmodule

// File: tb/tb_object_motion_pool.sv
// Directed bench for object_motion_pool: allocator table plus motion, lifetime,
// exit, bounce and reset sequences with hand-computed expectations.
module tb_object_motion_pool;
    localparam int N = 4;

    logic            clk_centi_second = 1'b0;
    logic            reset = 1'b1;
    logic            spawn_valid = 1'b0;
    logic            spawn_ready;
    logic [9:0]      spawn_pos_x = '0, spawn_pos_y = '0, spawn_w = '0, spawn_h = '0;
    logic [2:0]      spawn_dir = '0;
    logic [4:0]      spawn_speed = '0;
    logic [7:0]      spawn_life = '0;
    logic [1:0]      spawn_mode = '0;
    logic [3:0]      spawn_slot_id;
    logic [9:0]      win_x1 = 10'd0, win_y1 = 10'd0, win_x2 = 10'd200, win_y2 = 10'd200;
    logic [N-1:0]    kill_mask = '0;
    logic [N-1:0]    slot_active;
    logic [11*N-1:0] obj_x_flat, obj_y_flat;
    logic [10*N-1:0] obj_w_flat, obj_h_flat;
    logic [N-1:0]    destroy_pulse;
    logic [4:0]      active_count;

    object_motion_pool dut (
        .clk_centi_second (clk_centi_second),
        .reset            (reset),
        .spawn_valid      (spawn_valid),
        .spawn_ready      (spawn_ready),
        .spawn_pos_x      (spawn_pos_x),
        .spawn_pos_y      (spawn_pos_y),
        .spawn_w          (spawn_w),
        .spawn_h          (spawn_h),
        .spawn_dir        (spawn_dir),
        .spawn_speed      (spawn_speed),
        .spawn_life       (spawn_life),
        .spawn_mode       (spawn_mode),
        .spawn_slot_id    (spawn_slot_id),
        .win_x1           (win_x1),
        .win_y1           (win_y1),
        .win_x2           (win_x2),
        .win_y2           (win_y2),
        .kill_mask        (kill_mask),
        .slot_active      (slot_active),
        .obj_x_flat       (obj_x_flat),
        .obj_y_flat       (obj_y_flat),
        .obj_w_flat       (obj_w_flat),
        .obj_h_flat       (obj_h_flat),
        .destroy_pulse    (destroy_pulse),
        .active_count     (active_count)
    );

    always #5 clk_centi_second = ~clk_centi_second;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       valid;
        logic [3:0] kill;
        logic       exp_ready;
        logic       chk_id;
        logic [3:0] exp_id;
        logic [3:0] exp_active;
        logic [3:0] exp_pulse;
        int         exp_count;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ox(input int i);
        return int'($signed(obj_x_flat[i*11 +: 11]));
    endfunction

    function automatic int oy(input int i);
        return int'($signed(obj_y_flat[i*11 +: 11]));
    endfunction

    task automatic tick();
        @(posedge clk_centi_second);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        spawn_valid = 1'b0;
        kill_mask = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic spawn(input int x, input int y, input int w, input int h, input int dir,
                         input int spd, input int life, input int mode, input int exp_id,
                         input string name);
        spawn_pos_x = 10'(x);
        spawn_pos_y = 10'(y);
        spawn_w     = 10'(w);
        spawn_h     = 10'(h);
        spawn_dir   = 3'(dir);
        spawn_speed = 5'(spd);
        spawn_life  = 8'(life);
        spawn_mode  = 2'(mode);
        spawn_valid = 1'b1;
        #1;
        check({name, " ready"}, int'(spawn_ready), 1);
        check({name, " id"}, int'(spawn_slot_id), exp_id);
        tick();
        spawn_valid = 1'b0;
    endtask

    // counts edges until destroy_pulse[slot] is seen, giving up after limit
    task automatic wait_pulse(input int slot, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!destroy_pulse[slot] && n < limit);
    endtask

    initial begin
        int n;

        tbl[0] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'd0, 4'b0001, 4'b0000, 1};
        tbl[1] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'd1, 4'b0011, 4'b0000, 2};
        tbl[2] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'd2, 4'b0111, 4'b0000, 3};
        tbl[3] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'd3, 4'b1111, 4'b0000, 4};
        tbl[4] = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'd0, 4'b1011, 4'b0100, 3};
        tbl[5] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'd2, 4'b1111, 4'b0000, 4};
        tbl[6] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'd0, 4'b1110, 4'b0001, 3};
        tbl[7] = '{1'b1, 4'b1000, 1'b1, 1'b1, 4'd0, 4'b0111, 4'b1000, 3};
        tbl[8] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'd3, 4'b0111, 4'b0000, 3};

        // reset state
        tick();
        do_reset();
        check("rst active", int'(slot_active), 0);
        check("rst count", int'(active_count), 0);
        check("rst pulse", int'(destroy_pulse), 0);
        check("rst ready", int'(spawn_ready), 1);
        check("rst x zero", int'(obj_x_flat != '0), 0);
        check("rst w zero", int'(obj_w_flat != '0), 0);

        // straight-line motion to the right, 1 px per tick
        spawn(100, 100, 20, 30, 2, 8, 0, 0, 0, "t1");
        check("t1 active", int'(slot_active), 1);
        check("t1 x0", ox(0), 100);
        check("t1 w", int'(obj_w_flat[9:0]), 20);
        check("t1 h", int'(obj_h_flat[9:0]), 30);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) check("t1 x1", ox(0), 101);
        end
        check("t1 x10", ox(0), 110);
        check("t1 y10", oy(0), 100);

        // allocator table: fill, kill, regrant, spawn alongside a free
        do_reset();
        spawn_pos_x = 10'd50; spawn_pos_y = 10'd50; spawn_w = 10'd8; spawn_h = 10'd8;
        spawn_dir = 3'd0; spawn_speed = '0; spawn_life = '0; spawn_mode = 2'd0;
        for (int k = 0; k < 9; k++) begin
            spawn_valid = tbl[k].valid;
            kill_mask = tbl[k].kill;
            #1;
            check($sformatf("v%0d ready", k), int'(spawn_ready), int'(tbl[k].exp_ready));
            if (tbl[k].chk_id)
                check($sformatf("v%0d id", k), int'(spawn_slot_id), int'(tbl[k].exp_id));
            tick();
            check($sformatf("v%0d active", k), int'(slot_active), int'(tbl[k].exp_active));
            check($sformatf("v%0d pulse", k), int'(destroy_pulse), int'(tbl[k].exp_pulse));
            check($sformatf("v%0d count", k), int'(active_count), tbl[k].exp_count);
        end
        spawn_valid = 1'b0;
        kill_mask = '0;

        // lifetime and prescaler period
        do_reset();
        spawn(10, 10, 4, 4, 0, 0, 1, 0, 0, "t3a");
        wait_pulse(0, 300, n);
        check("t3 first sec edges", n, 99);
        spawn(10, 10, 4, 4, 0, 0, 2, 0, 0, "t3b");
        wait_pulse(0, 150, n);
        check("t3 life2 still active", int'(slot_active[0]), 1);
        check("t3 life2 no early pulse", n, 150);
        wait_pulse(0, 200, n);
        check("t3 life2 remaining edges", n, 49);
        check("t3 life2 freed", int'(slot_active[0]), 0);
        spawn(10, 10, 4, 4, 0, 0, 1, 0, 0, "t3c");
        wait_pulse(0, 300, n);
        check("t3 period edges", n, 99);

        // screen-exit to the left through negative x
        do_reset();
        spawn(5, 100, 10, 10, 6, 8, 0, 1, 0, "t4");
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 6)  check("t4 x at -1", ox(0), -1);
            if (k == 14) check("t4 x at -9", ox(0), -9);
        end
        check("t4 active before exit", int'(slot_active[0]), 1);
        tick();
        check("t4 freed", int'(slot_active[0]), 0);
        check("t4 pulse", int'(destroy_pulse), 1);
        check("t4 x zero", ox(0), 0);
        tick();
        check("t4 pulse one cycle", int'(destroy_pulse), 0);

        // bounce in window 0..200
        do_reset();
        spawn(190, 50, 10, 10, 1, 8, 0, 3, 0, "t5");
        tick();
        check("t5 clamp x", ox(0), 190);
        check("t5 y", oy(0), 49);
        tick();
        check("t5 after mirror x", ox(0), 189);
        check("t5 after mirror y", oy(0), 48);
        spawn(1, 1, 10, 10, 7, 8, 0, 3, 1, "t5c");
        check("t5c x start", ox(1), 1);
        tick();
        check("t5c x at 0", ox(1), 0);
        tick();
        check("t5c x clamp", ox(1), 0);
        check("t5c y clamp", oy(1), 0);
        tick();
        check("t5c corner x", ox(1), 1);
        check("t5c corner y", oy(1), 1);
        check("t5 still active", int'(slot_active), 3);

        // reset mid-motion, with a kill on the same edge
        do_reset();
        spawn(20, 20, 5, 5, 2, 8, 0, 0, 0, "t6a");
        spawn(40, 40, 5, 5, 2, 8, 0, 0, 1, "t6b");
        spawn(60, 60, 5, 5, 2, 8, 0, 0, 2, "t6c");
        tick();
        tick();
        check("t6 count before", int'(active_count), 3);
        reset = 1'b1;
        kill_mask = 4'b0001;
        tick();
        check("t6 active", int'(slot_active), 0);
        check("t6 pulse", int'(destroy_pulse), 0);
        check("t6 count", int'(active_count), 0);
        check("t6 x zero", int'(obj_x_flat != '0), 0);
        check("t6 y zero", int'(obj_y_flat != '0), 0);
        check("t6 ready", int'(spawn_ready), 1);
        reset = 1'b0;
        kill_mask = '0;
        tick();
        check("t6 pulse after", int'(destroy_pulse), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
